// File: rtl/svtime_pkg.sv
// Shared types and calendar constants for the time keeper.
package svtime_pkg;

  // Alarm controller states.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RINGING = 2'd1,
    SNOOZED = 2'd2
  } alarm_state_e;

  localparam int SEC_PER_MIN   = 60;
  localparam int MIN_PER_HOUR  = 60;
  localparam int HOUR_PER_DAY  = 24;
  localparam int DAYS_PER_WEEK = 7;

  // Width of the ring and snooze second counters.
  localparam int CNT_W = 17;

  // True when every field of a load request is a legal calendar value.
  function automatic logic load_in_range(
    input logic [5:0] sec,
    input logic [5:0] min,
    input logic [4:0] hour,
    input logic [2:0] wday
  );
    return (sec  <= 6'(SEC_PER_MIN - 1))  &&
           (min  <= 6'(MIN_PER_HOUR - 1)) &&
           (hour <= 5'(HOUR_PER_DAY - 1)) &&
           (wday <= 3'(DAYS_PER_WEEK - 1));
  endfunction

endpackage

// File: rtl/time_prescaler.sv
// Divides clk down to a one-cycle tick every TICKS_PER_SEC cycles.
module time_prescaler #(
  parameter int TICKS_PER_SEC = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic tick
);

  localparam int CW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICKS_PER_SEC - 1);

  logic [CW-1:0] count_reg;

  // The tick is the last count of each second.
  assign tick = (count_reg == LAST);

  // Free-running modulo counter; a clear restarts the second from zero.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count_reg <= '0;
    end else if (tick) begin
      count_reg <= '0;
    end else begin
      count_reg <= count_reg + 1'b1;
    end
  end

endmodule

// File: rtl/time_keeper.sv
// Weekday clock with load port, rollover strobes and a snoozable alarm.
module time_keeper
  import svtime_pkg::*;
#(
  parameter int TICKS_PER_SEC = 4,
  parameter int RING_SEC      = 60,
  parameter int SNOOZE_MIN    = 9
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       load_valid,
  input  logic [5:0] ld_sec,
  input  logic [5:0] ld_min,
  input  logic [4:0] ld_hour,
  input  logic [2:0] ld_wday,
  input  logic       alarm_en,
  input  logic [4:0] alarm_hour,
  input  logic [5:0] alarm_min,
  input  logic       snooze,
  input  logic       stop,
  output logic [5:0] tm_sec,
  output logic [5:0] tm_min,
  output logic [4:0] tm_hour,
  output logic [2:0] tm_wday,
  output logic       sec_pulse,
  output logic       min_pulse,
  output logic       hour_pulse,
  output logic       day_pulse,
  output logic       load_err,
  output logic       ring
);

  localparam logic [CNT_W-1:0] RING_LOAD   = CNT_W'(RING_SEC);
  localparam logic [CNT_W-1:0] SNOOZE_LOAD = CNT_W'(SNOOZE_MIN * SEC_PER_MIN);

  logic tick;
  logic load_ok;
  logic advance;

  logic       sec_wrap, min_wrap, hour_wrap, day_wrap;
  logic [5:0] sec_inc, min_inc;
  logic [4:0] hour_inc;
  logic [2:0] wday_inc;
  logic       alarm_hit;

  alarm_state_e     state_reg;
  logic [CNT_W-1:0] ring_cnt_reg;
  logic [CNT_W-1:0] snooze_cnt_reg;

  // A legal load overrides the tick of the same cycle, so only un-loaded ticks advance time.
  assign load_ok = load_valid && load_in_range(ld_sec, ld_min, ld_hour, ld_wday);
  assign advance = tick && !load_ok;

  time_prescaler #(
    .TICKS_PER_SEC(TICKS_PER_SEC)
  ) u_prescaler (
    .clk  (clk),
    .rst  (rst),
    .clear(load_ok),
    .tick (tick)
  );

  // Time one second ahead of the current value, with the carry chain.
  always_comb begin
    sec_wrap  = (tm_sec == 6'(SEC_PER_MIN - 1));
    min_wrap  = sec_wrap && (tm_min == 6'(MIN_PER_HOUR - 1));
    hour_wrap = min_wrap && (tm_hour == 5'(HOUR_PER_DAY - 1));
    day_wrap  = hour_wrap && (tm_wday == 3'(DAYS_PER_WEEK - 1));
    sec_inc   = sec_wrap ? 6'd0 : tm_sec + 6'd1;
    min_inc   = !sec_wrap ? tm_min : (min_wrap ? 6'd0 : tm_min + 6'd1);
    hour_inc  = !min_wrap ? tm_hour : (hour_wrap ? 5'd0 : tm_hour + 5'd1);
    wday_inc  = !hour_wrap ? tm_wday : (day_wrap ? 3'd0 : tm_wday + 3'd1);
    alarm_hit = advance && alarm_en && (sec_inc == 6'd0) &&
                (min_inc == alarm_min) && (hour_inc == alarm_hour);
  end

  // Time-of-day registers, rollover strobes and load error flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      tm_sec     <= '0;
      tm_min     <= '0;
      tm_hour    <= '0;
      tm_wday    <= '0;
      sec_pulse  <= 1'b0;
      min_pulse  <= 1'b0;
      hour_pulse <= 1'b0;
      day_pulse  <= 1'b0;
      load_err   <= 1'b0;
    end else begin
      if (load_ok) begin
        tm_sec  <= ld_sec;
        tm_min  <= ld_min;
        tm_hour <= ld_hour;
        tm_wday <= ld_wday;
      end else if (advance) begin
        tm_sec  <= sec_inc;
        tm_min  <= min_inc;
        tm_hour <= hour_inc;
        tm_wday <= wday_inc;
      end
      sec_pulse  <= advance;
      min_pulse  <= advance && sec_wrap;
      hour_pulse <= advance && min_wrap;
      day_pulse  <= advance && hour_wrap;
      load_err   <= load_valid && !load_ok;
    end
  end

  // Alarm controller; ring is registered from the state being entered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= IDLE;
      ring_cnt_reg   <= '0;
      snooze_cnt_reg <= '0;
      ring           <= 1'b0;
    end else if (!alarm_en) begin
      state_reg <= IDLE;
      ring      <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (alarm_hit) begin
            state_reg    <= RINGING;
            ring_cnt_reg <= RING_LOAD;
            ring         <= 1'b1;
          end else begin
            ring <= 1'b0;
          end
        end
        RINGING: begin
          if (stop) begin
            state_reg <= IDLE;
            ring      <= 1'b0;
          end else if (snooze) begin
            state_reg      <= SNOOZED;
            snooze_cnt_reg <= SNOOZE_LOAD;
            ring           <= 1'b0;
          end else if (advance) begin
            if (ring_cnt_reg <= CNT_W'(1)) begin
              state_reg    <= IDLE;
              ring_cnt_reg <= '0;
              ring         <= 1'b0;
            end else begin
              ring_cnt_reg <= ring_cnt_reg - 1'b1;
              ring         <= 1'b1;
            end
          end else begin
            ring <= 1'b1;
          end
        end
        SNOOZED: begin
          if (stop) begin
            state_reg <= IDLE;
            ring      <= 1'b0;
          end else if (advance) begin
            if (snooze_cnt_reg <= CNT_W'(1)) begin
              state_reg      <= RINGING;
              snooze_cnt_reg <= '0;
              ring_cnt_reg   <= RING_LOAD;
              ring           <= 1'b1;
            end else begin
              snooze_cnt_reg <= snooze_cnt_reg - 1'b1;
              ring           <= 1'b0;
            end
          end else begin
            ring <= 1'b0;
          end
        end
        default: begin
          state_reg <= IDLE;
          ring      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/time_keeper.md
TIME_KEEPER -- requirements
Module: time_keeper

Interface
REQ-001 Parameter TICKS_PER_SEC, default 4, clk cycles per simulated second; values below 1 are illegal.
REQ-002 Parameter RING_SEC, default 60, seconds the alarm rings before it stops on its own.
REQ-003 Parameter SNOOZE_MIN, default 9, snooze length in minutes.
REQ-004 clk  input  1  sole clock; all logic on the rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 load_valid  input  1  one-cycle strobe to load the ld_* fields.
REQ-007 ld_sec, ld_min  input  6 each; ld_hour  input  5; ld_wday  input  3  load values.
REQ-008 alarm_en  input  1; alarm_hour  input  5; alarm_min  input  6  alarm setup.
REQ-009 snooze, stop  input  1 each  one-cycle user strobes.
REQ-010 tm_sec, tm_min  output  6 each; tm_hour  output  5; tm_wday  output  3  current time, registered.
REQ-011 sec_pulse, min_pulse, hour_pulse, day_pulse  output  1 each  one-cycle rollover strobes.
REQ-012 load_err  output  1; ring  output  1  ring is high throughout the RINGING state.

Function
REQ-013 Prescaler counts 0..TICKS_PER_SEC-1 and wraps; a tick occurs on the cycle it is at TICKS_PER_SEC-1.
REQ-014 On a tick, tm_sec increments and sec_pulse is high on the next cycle, aligned with the new tm_* values.
REQ-015 Rollovers: sec 59->0 increments min; min 59->0 increments hour; hour 23->0 increments wday; wday 6->0.
REQ-016 Rollover pulses are issued together: 23:59:59 plus a tick asserts all four pulses in one cycle.
REQ-017 A valid load (sec<=59, min<=59, hour<=23, wday<=6) updates tm_* on the next cycle and clears the prescaler to 0.
REQ-018 An out-of-range load is ignored and asserts load_err for one cycle; the prescaler keeps running.
REQ-019 Load coincident with a tick: the load wins, the tick is discarded, and no pulses are issued.
REQ-020 Alarm FSM states are IDLE, RINGING and SNOOZED.
REQ-021 IDLE->RINGING only on a tick whose new time equals alarm_hour:alarm_min:00 while alarm_en=1; a load never triggers the alarm.
REQ-022 On entry to RINGING, the ring-second counter is set to RING_SEC.
REQ-023 In RINGING the counter decrements on each tick; at 0 the FSM returns to IDLE.
REQ-024 RINGING+snooze -> SNOOZED, with the snooze counter set to SNOOZE_MIN*60 seconds (17-bit counter).
REQ-025 SNOOZED: the counter decrements on each tick; at 0 the FSM returns to RINGING and the ring counter reloads.
REQ-026 stop in RINGING or SNOOZED -> IDLE; stop and snooze in the same cycle: stop wins.
REQ-027 alarm_en=0 forces IDLE from any state on the next cycle.
REQ-028 ring is registered and rises on the same cycle as the triggering sec_pulse.
REQ-029 A load during RINGING or SNOOZED does not change the FSM state.

Reset
REQ-030 rst=1 takes priority over every other input.
REQ-031 Reset values: tm_* all 0, prescaler 0, FSM IDLE, both counters 0.
REQ-032 Reset values: all pulses 0, load_err 0, ring 0.
REQ-033 Reset asserted mid-RINGING or mid-SNOOZED gives ring=0 and 00:00:00 day 0 on the next cycle.

Structure
REQ-034 svtime_pkg holds the alarm_state_e enum (IDLE, RINGING, SNOOZED).
REQ-035 svtime_pkg holds the constants SEC_PER_MIN=60, MIN_PER_HOUR=60, HOUR_PER_DAY=24, DAYS_PER_WEEK=7.
REQ-036 The prescaler is a sub-module time_prescaler with parameter TICKS_PER_SEC and outputs tick; it is cleared by rst or by a valid load.

Verification (TICKS_PER_SEC=2)
REQ-037 Load 23:59:58 day 6, then run 4 cycles -> the second sec_pulse shows 00:00:00 day 0 with all four pulses high for one cycle.
REQ-038 Load ld_sec=60 -> load_err high for one cycle and tm_* unchanged; ld_hour=24 gives the same result.
REQ-039 Alarm 07:00 with alarm_en=1, load 06:59:59 -> ring rises with the 07:00:00 sec_pulse and falls after 60 further ticks.
REQ-040 snooze while ringing -> ring low for 540 ticks, then high again; stop and snooze in the same cycle -> IDLE, ring=0.
REQ-041 Load asserted on the tick cycle -> the loaded value appears, with no sec_pulse and the prescaler at 0.
REQ-042 rst asserted during RINGING -> next cycle ring=0, tm_* all 0, and no pulses.
